// File: rtl/irq_event_aggregator.sv
// Purpose: synchronise up to 16 interrupt lines, latch them as level or rising-edge events, mask and prioritise them for the CPU.
// Latency: irq_in -> irq_out/irq_id is SYNC_STAGES+2 clocks (4 at default); readdata is valid one clock after the address.
// Backpressure: none; the Avalon-MM slave has zero wait states and every input is sampled every cycle.
module irq_event_aggregator #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq_out,
  output logic [3:0]         irq_id
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_ID      = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;
  localparam logic [2:0] ADDR_EVCOUNT = 3'd6;

  // Synchroniser chain; the last stage is the clean level used everywhere else.
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_s;
  logic [NUM_SRC-1:0] s_dly_q;
  logic [NUM_SRC-1:0] rise;

  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [15:0]        evcnt_q, evcnt_d;
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_out_q, irq_out_d;
  logic [3:0]         irq_id_q, irq_id_d;

  logic               wr_en;
  logic               wr_pend, wr_mask, wr_mode, wr_cnt;
  logic [NUM_SRC-1:0] wdata_src;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] mode_set;
  logic [NUM_SRC-1:0] active;
  logic [3:0]         act_id;
  logic               unused_wdata;

  // Upper writedata bits have no backing storage when NUM_SRC < 16.
  assign unused_wdata = ^writedata;

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign rise      = sync_s & ~s_dly_q;

  assign wr_en     = chipselect & ~write_n;
  assign wr_pend   = wr_en && (address == ADDR_PENDING);
  assign wr_mask   = wr_en && (address == ADDR_MASK);
  assign wr_mode   = wr_en && (address == ADDR_MODE);
  assign wr_cnt    = wr_en && (address == ADDR_EVCOUNT);
  assign wdata_src = writedata[NUM_SRC-1:0];
  assign w1c       = wr_pend ? wdata_src : '0;
  // Bits switching from level to edge mode in this cycle.
  assign mode_set  = wr_mode ? (wdata_src & ~mode_q) : '0;
  assign active    = pend_q & mask_q;

  // Zero-extend a per-source vector to the 16-bit register width.
  function automatic logic [15:0] widen(input logic [NUM_SRC-1:0] v);
    logic [15:0] r;
    r = '0;
    r[NUM_SRC-1:0] = v;
    return r;
  endfunction

  // Lowest-index active source wins; scanning downward lets the lowest set bit be written last.
  always_comb begin
    act_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) act_id = i[3:0];
    end
  end

  // Pending: edge bits set on rise (set beats W1C), level bits track the line, newly edge bits restart from rise.
  always_comb begin
    pend_d = (mode_q & (rise | (pend_q & ~w1c)))
           | (~mode_q & ~mode_set & sync_s)
           | (mode_set & rise);
    mask_d = wr_mask ? wdata_src : mask_q;
    mode_d = wr_mode ? wdata_src : mode_q;
  end

  // Event counter: one count per cycle with any unmasked edge event, saturating, and any write clears it.
  always_comb begin
    evcnt_d = evcnt_q;
    if (wr_cnt) begin
      evcnt_d = '0;
    end else if ((|(rise & mode_q & mask_q)) && (evcnt_q != 16'hFFFF)) begin
      evcnt_d = evcnt_q + 16'd1;
    end
  end

  // Read mux and CPU-facing outputs, all registered every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_PENDING: readdata_d = widen(pend_q);
      ADDR_MASK:    readdata_d = widen(mask_q);
      ADDR_MODE:    readdata_d = widen(mode_q);
      ADDR_ACTIVE:  readdata_d = widen(active);
      ADDR_ID:      readdata_d = {|active, 11'b0, act_id};
      ADDR_RAW:     readdata_d = widen(sync_s);
      ADDR_EVCOUNT: readdata_d = evcnt_q;
      default:      readdata_d = '0;
    endcase
    irq_out_d = |active;
    irq_id_d  = act_id;
  end

  // Synchroniser flops and the one-cycle delayed level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_dly_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_dly_q <= sync_s;
    end
  end

  // Register state and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      evcnt_q    <= '0;
      readdata_q <= '0;
      irq_out_q  <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      evcnt_q    <= evcnt_d;
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;
  assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_irq_event_aggregator.sv
// Bench for irq_event_aggregator: directed register/latency scenarios plus randomized traffic,
// every cycle compared against a cycle-level behavioural model of the register map.
// Inputs driven at the falling edge, outputs sampled at the falling edge or 1 ns after the rising edge.
module tb_irq_event_aggregator;

  localparam int N  = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  irq_in;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic          irq_out;
  logic [3:0]    irq_id;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0]  irq_v;

  // Reference model state: values the DUT registers hold after the most recent rising edge.
  logic [N-1:0]  m_q [$];
  logic [N-1:0]  m_s, m_sd, m_pend, m_mask, m_mode;
  logic [15:0]   m_cnt, m_rd;
  logic          m_irq;
  logic [3:0]    m_id;

  always #5 clk = ~clk;

  irq_event_aggregator #(.NUM_SRC(N), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_out    (irq_out),
    .irq_id     (irq_id)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < SS - 1; i++) m_q.push_back('0);
    m_s = '0; m_sd = '0; m_pend = '0; m_mask = '0; m_mode = '0;
    m_cnt = '0; m_rd = '0; m_irq = 1'b0; m_id = '0;
  endtask

  // Advance the model across one rising edge with the given bus/line inputs.
  task automatic model_step(input logic [N-1:0] irq, input logic cs, input logic wn,
                            input logic [2:0] a, input logic [15:0] wd);
    logic [N-1:0] rise, act, np, wv;
    logic [15:0]  rd;
    logic [7:0]   wr;
    rise = m_s & ~m_sd;
    act  = m_pend & m_mask;
    wv   = wd[N-1:0];
    for (int k = 0; k < 8; k++) wr[k] = cs && !wn && (a == k[2:0]);
    case (a)
      3'd0:    rd = 16'(m_pend);
      3'd1:    rd = 16'(m_mask);
      3'd2:    rd = 16'(m_mode);
      3'd3:    rd = 16'(act);
      3'd4:    rd = (act != 0) ? (16'h8000 | 16'(lowest(act))) : 16'h0000;
      3'd5:    rd = 16'(m_s);
      3'd6:    rd = m_cnt;
      default: rd = 16'h0000;
    endcase
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i])               np[i] = m_s[i];
      else if (rise[i])             np[i] = 1'b1;
      else if (wr[0] && wv[i])      np[i] = 1'b0;
      else                          np[i] = m_pend[i];
      if (wr[2] && wv[i] && !m_mode[i]) np[i] = rise[i];
    end
    if (wr[6])                                               m_cnt = 16'h0000;
    else if (((rise & m_mode & m_mask) != 0) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_rd   = rd;
    m_irq  = (act != 0);
    m_id   = 4'(lowest(act));
    m_pend = np;
    if (wr[1]) m_mask = wv;
    if (wr[2]) m_mode = wv;
    m_q.push_back(irq);
    m_sd = m_s;
    m_s  = m_q.pop_front();
  endtask

  // One clock: check outputs against the model, drive new inputs, step the model, cross the edge.
  task automatic cyc(input logic [N-1:0] irq, input logic cs, input logic wn,
                     input logic [2:0] a, input logic [15:0] wd);
    @(negedge clk);
    chk_eq("readdata", readdata, m_rd);
    chk_eq("irq_out", irq_out, m_irq);
    chk_eq("irq_id", irq_id, m_id);
    irq_in = irq; chipselect = cs; write_n = wn; address = a; writedata = wd;
    model_step(irq, cs, wn, a, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(irq_v, 1'b1, 1'b1, a, 16'h0000);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cyc(irq_v, 1'b1, 1'b0, a, d);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk_eq("rst_readdata", readdata, 0);
    chk_eq("rst_irq_out", irq_out, 0);
    chk_eq("rst_irq_id", irq_id, 0);
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; irq_v = '0; irq_in = '0; address = '0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("init_readdata", readdata, 0);
    chk_eq("init_irq_out", irq_out, 0);
    chk_eq("init_irq_id", irq_id, 0);
    reset_n = 1'b1;

    // All addresses read zero after reset.
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      chk_eq($sformatf("reset_rd%0d", a), readdata, 0);
    end

    // Level source 0: latency and ID register.
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h0000);
    rd(3'd3); rd(3'd3);
    irq_v = 8'h01;
    rd(3'd4); rd(3'd4); rd(3'd4);
    chk_eq("lvl_irq_early", irq_out, 0);
    rd(3'd4);
    chk_eq("lvl_irq_out", irq_out, 1);
    chk_eq("lvl_irq_id", irq_id, 0);
    rd(3'd4);
    chk_eq("lvl_id_reg", readdata, 16'h8000);
    irq_v = 8'h00;
    rd(3'd4); rd(3'd4); rd(3'd4);
    chk_eq("lvl_drop_hold", irq_out, 1);
    rd(3'd4);
    chk_eq("lvl_drop", irq_out, 0);

    // Edge sources 1 and 2 pulsed together.
    wr(3'd2, 16'h0006);
    wr(3'd1, 16'h0006);
    irq_v = 8'h06;
    rd(3'd0); rd(3'd0);
    irq_v = 8'h00;
    repeat (4) rd(3'd0);
    rd(3'd0);
    chk_eq("edge_pending", readdata, 16'h0006);
    chk_eq("edge_irq_id", irq_id, 1);
    rd(3'd6);
    chk_eq("edge_evcount", readdata, 16'h0001);
    wr(3'd0, 16'h0002);
    rd(3'd0);
    chk_eq("w1c_pending", readdata, 16'h0004);
    chk_eq("w1c_irq_id", irq_id, 2);

    // Source 3: W1C lands in the same cycle as its rise; set must win.
    wr(3'd2, 16'h000E);
    wr(3'd1, 16'h000E);
    irq_v = 8'h08;
    rd(3'd0); rd(3'd0);
    wr(3'd0, 16'h0008);
    rd(3'd0);
    chk_eq("set_wins", readdata, 16'h000C);

    // Mask drop and restore.
    wr(3'd1, 16'h0000);
    chk_eq("mask0_hold", irq_out, 1);
    rd(3'd0);
    chk_eq("mask0_irq_out", irq_out, 0);
    chk_eq("mask0_pending", readdata, 16'h000C);
    wr(3'd1, 16'h000E);
    rd(3'd0);
    chk_eq("remask_irq_out", irq_out, 1);
    chk_eq("remask_irq_id", irq_id, 2);

    // EVCOUNT saturation: sources 0 and 1 toggle in antiphase, giving an edge event every cycle.
    irq_v = 8'h00;
    wr(3'd2, 16'h0003);
    wr(3'd1, 16'h0003);
    for (int t = 0; t < 65600; t++) begin
      irq_v = {6'b0, ~t[0], t[0]};
      rd(3'd6);
    end
    chk_eq("evcount_sat", readdata, 16'hFFFF);
    irq_v = {6'b0, irq_v[0], irq_v[1]};
    wr(3'd6, 16'h0000);
    irq_v = {6'b0, irq_v[0], irq_v[1]};
    rd(3'd6);
    chk_eq("evcount_clr", readdata, 16'h0000);
    irq_v = {6'b0, irq_v[0], irq_v[1]};
    rd(3'd6);
    chk_eq("evcount_after_clr", readdata, 16'h0001);

    // Randomized traffic with a mid-run asynchronous reset.
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) irq_v[b] = ~irq_v[b];
      cyc(irq_v, 1'($urandom_range(1)), ($urandom_range(3) != 0), 3'($urandom_range(7)), 16'($urandom));
      if (c == 1200) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
